// File: rtl/mmio_frame_sequencer_if.sv
// MMIO bus seen from the frame sequencer.
//   bus_req   : initiator asks the arbiter for the bus
//   bus_gnt   : arbiter grant
//   bus_addr  : MMIO address (bit 12 = coprocessor space)
//   bus_wdata : write data
//   bus_wren  : write strobe
//   bus_rdata : read data, combinational from bus_addr
// master = sequencer side, slave = arbiter/mux/responder side.
interface mmio_frame_sequencer_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_wren;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_addr, bus_wdata, bus_wren,
    input  bus_gnt, bus_rdata
  );

  modport slave (
    input  bus_req, bus_addr, bus_wdata, bus_wren,
    output bus_gnt, bus_rdata
  );
endinterface

// File: rtl/mmio_frame_sequencer.sv
// mmio_frame_sequencer: on each frame tick, takes the MMIO bus through a
// request/grant handshake and runs the fixed frame script: read both physics
// positions, write them to the collision units, let the collision units
// settle, read collision results back into the physics units, then write the
// positions to the VGA coprocessors.
//
// Optional feature: define MMIO_FRAME_SEQ_CTRL_FWD_EN to append four states
// that forward the two controller words (0x1200 -> 0x1010, 0x1280 -> 0x1090)
// before DONE.
//
// Ports:
//   clock, reset : rising-edge clock, async active-high reset
//   frame_tick   : one-cycle pulse starting a sequence
//   bus          : MMIO initiator (master modport)
//   busy         : state is not IDLE
//   done         : one-cycle pulse in the DONE state
//   overrun      : sticky, a tick arrived while busy
//   frame_count  : completed sequences, wraps at 16 bits
module mmio_frame_sequencer #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_tick,
  mmio_frame_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [15:0]           frame_count
);

  localparam logic [ADDR_W-1:0] A_POS1  = ADDR_W'(13'h1000);
  localparam logic [ADDR_W-1:0] A_POS2  = ADDR_W'(13'h1080);
  localparam logic [ADDR_W-1:0] A_COL1  = ADDR_W'(13'h1600);
  localparam logic [ADDR_W-1:0] A_COL2  = ADDR_W'(13'h1680);
  localparam logic [ADDR_W-1:0] A_PCOL1 = ADDR_W'(13'h101C);
  localparam logic [ADDR_W-1:0] A_PCOL2 = ADDR_W'(13'h109C);
  localparam logic [ADDR_W-1:0] A_VPOS1 = ADDR_W'(13'h1400);
  localparam logic [ADDR_W-1:0] A_VPOS2 = ADDR_W'(13'h1480);
`ifdef MMIO_FRAME_SEQ_CTRL_FWD_EN
  localparam logic [ADDR_W-1:0] A_CTL1  = ADDR_W'(13'h1200);
  localparam logic [ADDR_W-1:0] A_PCTL1 = ADDR_W'(13'h1010);
  localparam logic [ADDR_W-1:0] A_CTL2  = ADDR_W'(13'h1280);
  localparam logic [ADDR_W-1:0] A_PCTL2 = ADDR_W'(13'h1090);
`endif

  // Access states are listed in script order and DONE is last: a granted
  // access simply steps to the next encoding.
  typedef enum logic [4:0] {
    S_IDLE, S_REQ,
    S_RD_POS1, S_RD_POS2, S_WR_CPOS1, S_WR_CPOS2, S_SETTLE,
    S_RD_COLL1, S_RD_COLL2, S_WR_PCOL1, S_WR_PCOL2, S_WR_VPOS1, S_WR_VPOS2,
`ifdef MMIO_FRAME_SEQ_CTRL_FWD_EN
    S_RD_CTL1, S_WR_CTL1, S_RD_CTL2, S_WR_CTL2,
`endif
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] p1_q, p2_q, c1_q, c2_q;
  logic [DATA_W-1:0] p1_d, p2_d, c1_d, c2_d;
`ifdef MMIO_FRAME_SEQ_CTRL_FWD_EN
  logic [DATA_W-1:0] k1_q, k2_q, k1_d, k2_d;
`endif
  logic              req_q, req_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ovr_q;
  logic [15:0]       frame_count_q;
  logic              gnt;

  assign gnt = bus.bus_gnt;

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (frame_tick) state_d = S_REQ;
      S_REQ:   if (gnt) state_d = S_RD_POS1;
      S_DONE:  state_d = S_IDLE;
      default: if (gnt) state_d = state_t'(state_q + 5'd1);
    endcase
  end

  // Reads capture only on a granted cycle of their own state.
  always_comb begin
    p1_d = (state_q == S_RD_POS1  && gnt) ? bus.bus_rdata : p1_q;
    p2_d = (state_q == S_RD_POS2  && gnt) ? bus.bus_rdata : p2_q;
    c1_d = (state_q == S_RD_COLL1 && gnt) ? bus.bus_rdata : c1_q;
    c2_d = (state_q == S_RD_COLL2 && gnt) ? bus.bus_rdata : c2_q;
`ifdef MMIO_FRAME_SEQ_CTRL_FWD_EN
    k1_d = (state_q == S_RD_CTL1  && gnt) ? bus.bus_rdata : k1_q;
    k2_d = (state_q == S_RD_CTL2  && gnt) ? bus.bus_rdata : k2_q;
`endif
  end

  // Bus outputs are decoded from the next state and registered so they are
  // stable for the whole access cycle. Write data uses the post-capture
  // values because RD_CTLx is immediately followed by its WR_CTLx.
  always_comb begin
    addr_d  = '0;
    wren_d  = 1'b0;
    wdata_d = '0;
    case (state_d)
      S_RD_POS1:  addr_d = A_POS1;
      S_RD_POS2:  addr_d = A_POS2;
      S_WR_CPOS1: begin addr_d = A_COL1;  wren_d = 1'b1; wdata_d = p1_d; end
      S_WR_CPOS2: begin addr_d = A_COL2;  wren_d = 1'b1; wdata_d = p2_d; end
      S_SETTLE:   addr_d = A_COL1;
      S_RD_COLL1: addr_d = A_COL1;
      S_RD_COLL2: addr_d = A_COL2;
      S_WR_PCOL1: begin addr_d = A_PCOL1; wren_d = 1'b1; wdata_d = c1_d; end
      S_WR_PCOL2: begin addr_d = A_PCOL2; wren_d = 1'b1; wdata_d = c2_d; end
      S_WR_VPOS1: begin addr_d = A_VPOS1; wren_d = 1'b1; wdata_d = p1_d; end
      S_WR_VPOS2: begin addr_d = A_VPOS2; wren_d = 1'b1; wdata_d = p2_d; end
`ifdef MMIO_FRAME_SEQ_CTRL_FWD_EN
      S_RD_CTL1:  addr_d = A_CTL1;
      S_WR_CTL1:  begin addr_d = A_PCTL1; wren_d = 1'b1; wdata_d = k1_d; end
      S_RD_CTL2:  addr_d = A_CTL2;
      S_WR_CTL2:  begin addr_d = A_PCTL2; wren_d = 1'b1; wdata_d = k2_d; end
`endif
      default: ;
    endcase
    req_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      p1_q          <= '0;
      p2_q          <= '0;
      c1_q          <= '0;
      c2_q          <= '0;
`ifdef MMIO_FRAME_SEQ_CTRL_FWD_EN
      k1_q          <= '0;
      k2_q          <= '0;
`endif
      req_q         <= 1'b0;
      wren_q        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      ovr_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
`ifdef MMIO_FRAME_SEQ_CTRL_FWD_EN
      k1_q    <= k1_d;
      k2_q    <= k2_d;
`endif
      req_q   <= req_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      // DONE counts as busy, so a tick there is dropped as well
      if (frame_tick && state_q != S_IDLE) ovr_q <= 1'b1;
      if (state_q == S_DONE) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  // A revoked grant must never see a write; the registered access is held and
  // re-issued once the grant returns.
  assign bus.bus_wren  = wren_q & gnt;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign overrun       = ovr_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_mmio_frame_sequencer.sv
module tb_mmio_frame_sequencer;

`ifdef MMIO_FRAME_SEQ_CTRL_FWD_EN
  localparam int NACC = 15;
`else
  localparam int NACC = 11;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        busy, done, overrun;
  logic [15:0] frame_count;

  mmio_frame_sequencer_if #(.ADDR_W(13), .DATA_W(32)) bus ();

  mmio_frame_sequencer #(.ADDR_W(13), .DATA_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .bus         (bus.master),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  // responder: read-only register file seen through the MMIO mux
  logic [31:0] mem [0:8191];
  assign bus.bus_rdata = mem[bus.bus_addr];

  typedef struct packed {
    logic [12:0] a;
    logic        w;
    logic [31:0] d;
  } acc_t;

  acc_t   log_q[$];
  acc_t   exp_q[$];
  bit     log_en = 1'b0;
  int     wr_ungranted;
  bit     gnt_plan  [0:127];
  bit     tick_plan [0:127];
  int     n_chk = 0;
  int     n_fail = 0;
  logic [15:0] exp_cnt;

  // every granted access cycle is one bus transaction
  always @(negedge clock) begin
    if (log_en) begin
      if (bus.bus_wren && !bus.bus_gnt) wr_ungranted++;
      if (bus.bus_req && bus.bus_gnt && bus.bus_addr != 13'h0) begin
        acc_t e;
        e.a = bus.bus_addr;
        e.w = bus.bus_wren;
        e.d = bus.bus_wdata;
        log_q.push_back(e);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void add(input logic [12:0] a, input logic w, input logic [31:0] d);
    acc_t e;
    e.a = a; e.w = w; e.d = d;
    exp_q.push_back(e);
  endfunction

  // The frame script as a list of bus transactions; reads show no data.
  function automatic void build_exp();
    exp_q.delete();
    add(13'h1000, 1'b0, 32'h0);
    add(13'h1080, 1'b0, 32'h0);
    add(13'h1600, 1'b1, mem[13'h1000]);
    add(13'h1680, 1'b1, mem[13'h1080]);
    add(13'h1600, 1'b0, 32'h0);
    add(13'h1600, 1'b0, 32'h0);
    add(13'h1680, 1'b0, 32'h0);
    add(13'h101C, 1'b1, mem[13'h1600]);
    add(13'h109C, 1'b1, mem[13'h1680]);
    add(13'h1400, 1'b1, mem[13'h1000]);
    add(13'h1480, 1'b1, mem[13'h1080]);
`ifdef MMIO_FRAME_SEQ_CTRL_FWD_EN
    add(13'h1200, 1'b0, 32'h0);
    add(13'h1010, 1'b1, mem[13'h1200]);
    add(13'h1280, 1'b0, 32'h0);
    add(13'h1090, 1'b1, mem[13'h1280]);
`endif
  endfunction

  task automatic clear_plans();
    for (int i = 0; i < 128; i++) begin
      gnt_plan[i]  = 1'b1;
      tick_plan[i] = 1'b0;
    end
  endtask

  task automatic rand_mem();
    mem[13'h1000] = $urandom; mem[13'h1080] = $urandom;
    mem[13'h1600] = $urandom; mem[13'h1680] = $urandom;
    mem[13'h1200] = $urandom; mem[13'h1280] = $urandom;
  endtask

  // Runs one sequence with the current plans. rst_at>0 asserts reset during
  // that cycle and abandons the frame.
  task automatic run_frame(input string tag, input int rst_at);
    int pos, exp_done, done_c, done_w;
    logic busy_after;
    pos = 0; exp_done = 0; done_c = 0; done_w = 0; busy_after = 1'bx;
    // REQ plus each access needs one granted cycle; done follows the last
    for (int c = 1; c < 128 && exp_done == 0; c++)
      if (gnt_plan[c]) begin
        pos++;
        if (pos == 1 + NACC) exp_done = c + 1;
      end
    build_exp();
    log_q.delete();
    wr_ungranted = 0;
    log_en = 1'b1;
    @(negedge clock);
    frame_tick = 1'b1;
    bus.bus_gnt = 1'b1;
    @(posedge clock); #1;
    frame_tick = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      bus.bus_gnt = gnt_plan[c];
      frame_tick  = tick_plan[c];
      @(negedge clock);
      if (c == rst_at) begin
        reset = 1'b1;
        #1;
        chk({tag, "_rst_req"},  64'(bus.bus_req),  64'h0);
        chk({tag, "_rst_wren"}, 64'(bus.bus_wren), 64'h0);
        chk({tag, "_rst_busy"}, 64'(busy),         64'h0);
        chk({tag, "_rst_addr"}, 64'(bus.bus_addr), 64'h0);
        log_en = 1'b0;
        frame_tick = 1'b0;
        bus.bus_gnt = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_cnt = 16'h0;
        return;
      end
      if (done) begin
        done_w++;
        if (done_c == 0) done_c = c;
      end
      if (done_c != 0 && c == done_c + 1) busy_after = busy;
      @(posedge clock); #1;
      if (done_c != 0 && c > done_c + 1) break;
    end
    frame_tick = 1'b0;
    bus.bus_gnt = 1'b1;
    log_en = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, "_done_cycle"}, 64'(done_c), 64'(exp_done));
    chk({tag, "_done_width"}, 64'(done_w), 64'd1);
    chk({tag, "_busy_after"}, 64'(busy_after), 64'h0);
    chk({tag, "_wr_ungranted"}, 64'(wr_ungranted), 64'd0);
    chk({tag, "_trace_len"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_acc%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
    chk({tag, "_frame_count"}, 64'(frame_count), 64'(exp_cnt));
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    clear_plans();
    bus.bus_gnt = 1'b0;
    exp_cnt = 16'h0;

    // reset state
    #1;
    chk("reset_busy",   64'(busy),          64'h0);
    chk("reset_done",   64'(done),          64'h0);
    chk("reset_ovr",    64'(overrun),       64'h0);
    chk("reset_count",  64'(frame_count),   64'h0);
    chk("reset_req",    64'(bus.bus_req),   64'h0);
    chk("reset_addr",   64'(bus.bus_addr),  64'h0);
    chk("reset_wren",   64'(bus.bus_wren),  64'h0);
    chk("reset_wdata",  64'(bus.bus_wdata), 64'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_req", 64'(bus.bus_req), 64'h0);

    // basic frame
    mem[13'h1000] = 32'h016000FA;
    mem[13'h1080] = 32'h01A900FA;
    mem[13'h1600] = 32'h00000005;
    mem[13'h1680] = 32'h00000002;
    mem[13'h1200] = 32'h00000013;
    mem[13'h1280] = 32'h0000002C;
    run_frame("basic", 0);
    chk("basic_ovr", 64'(overrun), 64'h0);

    // grant held off 5 cycles, then dropped 2 cycles at WR_PCOL1
    clear_plans();
    for (int c = 1; c <= 5; c++) gnt_plan[c] = 1'b0;
    gnt_plan[14] = 1'b0;
    gnt_plan[15] = 1'b0;
    run_frame("handshake", 0);

    // random data and random grant gaps
    for (int r = 0; r < 3; r++) begin
      clear_plans();
      rand_mem();
      for (int c = 1; c < 40; c++) gnt_plan[c] = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rand%0d", r), 0);
    end

    // overrun: ticks in cycle 6 and in the DONE cycle are dropped
    clear_plans();
    rand_mem();
    tick_plan[6] = 1'b1;
    tick_plan[NACC + 2] = 1'b1;
    run_frame("overrun", 0);
    chk("overrun_set", 64'(overrun), 64'h1);
    repeat (3) @(negedge clock);
    chk("overrun_no_restart", 64'(busy), 64'h0);
    clear_plans();
    rand_mem();
    run_frame("after_ovr", 0);
    chk("overrun_sticky", 64'(overrun), 64'h1);

    // reset during RD_COLL1, then a clean frame with fresh data
    clear_plans();
    run_frame("midrst", 7);
    chk("midrst_ovr", 64'(overrun), 64'h0);
    chk("midrst_count", 64'(frame_count), 64'h0);
    rand_mem();
    run_frame("post_rst", 0);

    // counter wrap
    @(negedge clock);
    force dut.frame_count_q = 16'hFFFF;
    @(posedge clock); #1;
    release dut.frame_count_q;
    exp_cnt = 16'hFFFF;
    @(negedge clock);
    chk("preload", 64'(frame_count), 64'hFFFF);
    clear_plans();
    rand_mem();
    run_frame("wrap", 0);
    chk("wrap_zero", 64'(frame_count), 64'h0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
